// File: rtl/divider_seq.sv
// Sequential restoring-by-repeated-subtraction divider: operands loaded over one shared bus.
// Optional divide-by-zero detection is enabled by defining DIVZERO_CHK_EN.
//
// state | meaning
// IDLE  | waiting for start after reset
// LDA   | capture dividend from data_in into remainder
// LDB   | capture divisor, clear quotient and err
// SUB   | subtract divisor once per cycle while remainder >= divisor
// DONE  | result held until the next start
module divider_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_SUB  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      quot_q  <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    div_d   = div_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_LDA;
      end
      S_LDA: begin
        rem_d   = data_in;
        state_d = S_LDB;
      end
      S_LDB: begin
        div_d   = data_in;
        quot_d  = '0;
        err_d   = 1'b0;
`ifdef DIVZERO_CHK_EN
        if (data_in == '0) begin
          quot_d = '1;
          err_d  = 1'b1;
        end
`endif
        state_d = S_SUB;
      end
      S_SUB: begin
`ifdef DIVZERO_CHK_EN
        // a zero divisor passes through SUB once so done timing matches the Q=0 case
        if (div_q == '0) begin
          state_d = S_DONE;
        end else
`endif
        if (rem_q >= div_q) begin
          rem_d = rem_q - div_q;
          // saturate rather than wrap; only reachable with an unchecked zero divisor
          if (quot_q != '1) quot_d = quot_q + ONE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_LDA, S_LDB, S_SUB: busy = 1'b1;
      S_DONE:              done = 1'b1;
      default: ;
    endcase
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign err       = err_q;

endmodule

// File: tb/tb_divider_seq.sv
// Randomized and directed bench for divider_seq; expected outputs come from plain
// integer division and a cycle count since start, checked on every falling edge.
module tb_divider_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] quotient, remainder;
  logic        busy, done, err;

  divider_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  bit          tracking = 1'b0;
  int          n = 0;
  logic [15:0] cur_a = '0, cur_b = '0;
  logic [15:0] prev_q = '0, prev_r = '0;
  logic        prev_err = 1'b0;
  int          first_done = -1;
  int          busy_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_q(input logic [15:0] a, input logic [15:0] b);
    return (b == 0) ? 16'hFFFF : a / b;
  endfunction
  function automatic logic [15:0] m_r(input logic [15:0] a, input logic [15:0] b);
    return (b == 0) ? a : a % b;
  endfunction
  function automatic int m_lat(input logic [15:0] a, input logic [15:0] b);
    return (b == 0) ? 3 : 3 + int'(a / b);
  endfunction

  // n = number of rising edges since the edge that sampled start
  always @(negedge clk) begin
    if (!tracking) begin
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_q", quotient, 0);
      chk("idle_r", remainder, 0);
      chk("idle_err", err, 0);
    end else begin
      int          lat;
      logic [15:0] eq, er;
      logic        ee;
      lat = m_lat(cur_a, cur_b);
      if (n >= lat) begin
        eq = m_q(cur_a, cur_b); er = m_r(cur_a, cur_b); ee = (cur_b == 0);
      end else if (n >= 2) begin
        if (cur_b == 0) begin
          eq = 16'hFFFF; er = cur_a; ee = 1'b1;
        end else begin
          eq = 16'(n - 2);
          er = 16'(int'(cur_a) - (n - 2) * int'(cur_b));
          ee = 1'b0;
        end
      end else if (n == 1) begin
        eq = prev_q; er = cur_a; ee = prev_err;
      end else begin
        eq = prev_q; er = prev_r; ee = prev_err;
      end
      chk("busy", busy, (n < lat));
      chk("done", done, (n >= lat));
      chk("quotient", quotient, eq);
      chk("remainder", remainder, er);
      chk("err", err, ee);
      if (busy) busy_cnt++;
      if (done && first_done < 0) first_done = n;
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input bit poke, input int abort_at);
    int lat;
    lat = m_lat(a, b);
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'($urandom);
    @(posedge clk);
    if (tracking) begin
      prev_q = m_q(cur_a, cur_b); prev_r = m_r(cur_a, cur_b); prev_err = (cur_b == 0);
    end else begin
      prev_q = '0; prev_r = '0; prev_err = 1'b0;
    end
    cur_a = a; cur_b = b; n = 0; first_done = -1; busy_cnt = 0; tracking = 1'b1;
    while (n < lat + 2) begin
      @(negedge clk);
      data_in = (n == 0) ? a : (n == 1) ? b : 16'($urandom);
      start   = (poke && n < lat) ? 1'($urandom) : 1'b0;
      @(posedge clk);
      n++;
      if (abort_at > 0 && n == abort_at) begin
        #2 rst_n = 1'b0;
        tracking = 1'b0;
        #1;
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        start = 1'b0;
        #1 rst_n = 1'b1;
        return;
      end
    end
  endtask

  task automatic check_final(input string nm, input logic [15:0] eq, input logic [15:0] er,
                             input logic ee, input int elat);
    @(negedge clk);
    chk({nm, "_q"}, quotient, eq);
    chk({nm, "_r"}, remainder, er);
    chk({nm, "_err"}, err, ee);
    chk({nm, "_lat"}, first_done, elat);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op(16'd100, 16'd7, 1'b0, 0);
    check_final("d100_7", 16'd14, 16'd2, 1'b0, 17);

    run_op(16'd5, 16'd9, 1'b0, 0);
    check_final("d5_9", 16'd0, 16'd5, 1'b0, 3);
    chk("d5_9_busy_cycles", busy_cnt, 3);

    run_op(16'd0, 16'd5, 1'b1, 0);
    check_final("d0_5", 16'd0, 16'd0, 1'b0, 3);

    run_op(16'hFFFF, 16'd1, 1'b1, 0);
    check_final("dffff_1", 16'hFFFF, 16'd0, 1'b0, 65538);

`ifdef DIVZERO_CHK_EN
    run_op(16'd37, 16'd0, 1'b1, 0);
    check_final("d37_0", 16'hFFFF, 16'd37, 1'b1, 3);
`endif

    run_op(16'd1000, 16'd3, 1'b0, 40);
    run_op(16'd20, 16'd4, 1'b0, 0);
    check_final("d20_4", 16'd5, 16'd0, 1'b0, 8);

    run_op(16'd100, 16'd7, 1'b0, 0);
    run_op(16'd9, 16'd2, 1'b0, 0);
    check_final("d9_2", 16'd4, 16'd1, 1'b0, 7);

    for (int i = 0; i < 40; i++) begin
      int q, b, r;
      b = $urandom_range(1, 1500);
      q = $urandom_range(0, 40);
      r = $urandom_range(0, b - 1);
      if (i % 7 == 3) begin
        b = $urandom_range(1000, 65535);
        q = 0;
        r = $urandom_range(0, b - 1);
      end
`ifdef DIVZERO_CHK_EN
      if (i % 9 == 5) begin
        run_op(16'(q * 13 + r), 16'd0, 1'($urandom), 0);
        continue;
      end
`endif
      run_op(16'(q * b + r), 16'(b), 1'($urandom), (i % 11 == 6) ? 2 + q / 2 : 0);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
